// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: layer codes,
// per-layer dot-product lengths, the neuron FSM state type and the layer decoder.
package nn_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] LAYER_A = 2'b00;
    localparam logic [1:0] LAYER_B = 2'b01;
    localparam logic [1:0] LAYER_C = 2'b10;

    localparam logic [7:0] LEN_A = 8'd62;
    localparam logic [7:0] LEN_B = 8'd62;
    localparam logic [7:0] LEN_C = 8'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [7:0] len;
    } layer_cfg_t;

    // Code 2'b11 has no layer behind it; callers must ignore a start carrying it.
    function automatic layer_cfg_t decode_layer(input logic [1:0] code);
        layer_cfg_t cfg;
        cfg.legal = 1'b1;
        cfg.len   = LEN_A;
        case (code)
            LAYER_A: cfg.len = LEN_A;
            LAYER_B: cfg.len = LEN_B;
            LAYER_C: cfg.len = LEN_C;
            default: begin
                cfg.legal = 1'b0;
                cfg.len   = '0;
            end
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Bundle between the neuron MAC and its environment: controller handshake,
// feature/weight memory ports and the requantised result.
interface neuron_mac_if;
    import nn_pkg::*;

    logic                     start_signal;
    logic [1:0]               ctrl_data;
    logic                     ready_signal;
    logic [7:0]               index;
    logic signed [DATA_W-1:0] feature_data;
    logic signed [DATA_W-1:0] weight_data;
    logic signed [15:0]       bias;
    logic [7:0]               feature_addr;
    logic [7:0]               weight_addr;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output start_signal, ctrl_data, ready_signal, index,
               feature_data, weight_data, bias,
        input  feature_addr, weight_addr, out_data, out_valid, busy
    );

    modport slave (
        input  start_signal, ctrl_data, ready_signal, index,
               feature_data, weight_data, bias,
        output feature_addr, weight_addr, out_data, out_valid, busy
    );

endinterface

// File: rtl/relu_requant.sv
// Combinational output stage: bias add, ReLU, arithmetic shift and saturation
// of the accumulated dot product to an unsigned 8-bit activation.
module relu_requant
    import nn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [15:0]      i_bias,
    output logic [DATA_W-1:0]       o_data
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(255);

    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shifted;

    // One guard bit keeps the bias add exact for any accumulator value.
    assign w_sum     = (ACC_W + 1)'(i_acc) + (ACC_W + 1)'(i_bias);
    assign w_shifted = w_sum >>> SHIFT;

    always_comb begin
        o_data = '0;
        if (w_sum[ACC_W]) begin
            o_data = '0;
        end else if (w_shifted > SAT_MAX) begin
            o_data = '1;
        end else begin
            o_data = w_shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron dot-product engine: accepts controller indices, reads feature and
// weight memories, multiply-accumulates through a 3-stage pipeline and requantises.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input logic          clk,
    input logic          rst,
    neuron_mac_if.slave  bus
);

    state_e                   r_state;
    logic [7:0]               r_len;
    logic [7:0]               r_count;
    logic signed [15:0]       r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_tag0;
    logic                     r_tag1;
    logic signed [15:0]       r_prod;
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_valid;

    layer_cfg_t               w_cfg;
    logic                     w_start;
    logic                     w_accept;
    logic                     w_last;
    logic [7:0]               w_count_next;
    logic [DATA_W-1:0]        w_result;

    assign w_cfg        = decode_layer(bus.ctrl_data);
    assign w_start      = bus.start_signal && w_cfg.legal;
    assign w_accept     = (r_state == ST_RUN) && !bus.ready_signal && (bus.index < r_len);
    assign w_count_next = r_count + 8'd1;
    // Leave RUN on the edge that lands the final term, so FINISH sees the complete sum.
    assign w_last       = r_tag1 && (w_count_next == r_len);

    assign bus.feature_addr = bus.index;
    assign bus.weight_addr  = bus.index;
    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.busy         = (r_state != ST_IDLE);

    relu_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_relu_requant (
        .i_acc  (r_acc),
        .i_bias (r_bias),
        .o_data (w_result)
    );

    // The product stage runs every cycle; only its tag decides whether it is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
        end else begin
            r_prod <= bus.feature_data * bus.weight_data;
        end
    end

    // NOTE: every register here uses <= so each stage reads the previous stage's
    // pre-edge value; a blocking '=' would collapse the pipeline into one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_bias      <= '0;
            r_acc       <= '0;
            r_tag0      <= 1'b0;
            r_tag1      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_start) begin
            // A legal start from any state begins a fresh run and drops in-flight terms.
            r_state     <= ST_RUN;
            r_len       <= w_cfg.len;
            r_bias      <= bus.bias;
            r_count     <= '0;
            r_acc       <= '0;
            r_tag0      <= 1'b0;
            r_tag1      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_tag0      <= w_accept;
            r_tag1      <= r_tag0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (r_tag1) begin
                        r_acc   <= r_acc + ACC_W'(r_prod);
                        r_count <= w_count_next;
                        if (w_last) begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: two instances (SHIFT 0 and SHIFT 7) share one
// controller/memory stimulus stream; expected results are hand-computed constants.
module tb_neuron_mac;

    logic clk;
    logic rst;

    logic        start;
    logic [1:0]  ctrl;
    logic        ready;
    logic [7:0]  index;
    logic signed [15:0] bias;

    logic signed [7:0] fmem [0:255];
    logic signed [7:0] wmem [0:255];

    int checks;
    int errors;
    int pulses0;
    int pulses7;
    logic addr_bad;

    neuron_mac_if if0 ();
    neuron_mac_if if7 ();

    assign if0.start_signal = start;
    assign if0.ctrl_data    = ctrl;
    assign if0.ready_signal = ready;
    assign if0.index        = index;
    assign if0.bias         = bias;
    assign if7.start_signal = start;
    assign if7.ctrl_data    = ctrl;
    assign if7.ready_signal = ready;
    assign if7.index        = index;
    assign if7.bias         = bias;

    neuron_mac #(.ACC_W(24), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    neuron_mac #(.ACC_W(24), .SHIFT(7)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        if0.feature_data <= fmem[if0.feature_addr];
        if0.weight_data  <= wmem[if0.weight_addr];
        if7.feature_data <= fmem[if7.feature_addr];
        if7.weight_data  <= wmem[if7.weight_addr];
    end

    always @(negedge clk) begin
        if (if0.out_valid) pulses0++;
        if (if7.out_valid) pulses7++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic signed [7:0] f, input logic signed [7:0] w);
        for (int i = 0; i < 256; i++) begin
            fmem[i] = f;
            wmem[i] = w;
        end
    endtask

    task automatic start_run(input logic [1:0] layer, input logic signed [15:0] b);
        start = 1'b1; ctrl = layer; bias = b; ready = 1'b1; index = 8'hFF;
        step();
        start = 1'b0; ready = 1'b0; index = 8'hFF;
        step();
    endtask

    task automatic feed(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ready = 1'b0;
            index = 8'(i);
            #1;
            if (if0.feature_addr !== index || if0.weight_addr !== index) addr_bad = 1'b1;
            step();
        end
    endtask

    task automatic wait_result(output int lat, output logic [7:0] d0, output logic [7:0] d7,
                               output logic b3, output logic b4);
        lat = -1; d0 = '0; d7 = '0; b3 = 1'b0; b4 = 1'b0;
        ready = 1'b1;
        index = 8'hFF;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) b3 = if0.busy;
            if (k == 4) b4 = if0.busy;
            if (if0.out_valid && lat < 0) begin
                lat = k;
                d0  = if0.out_data;
                d7  = if7.out_data;
            end
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (if0.out_data !== 8'd0 || if7.out_data !== 8'd0) begin
            errors++; $display("FAIL reset_out_data: got %0d/%0d expected 0", if0.out_data, if7.out_data);
        end
        checks++;
        if (if0.out_valid !== 1'b0 || if7.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b/%b expected 0", if0.out_valid, if7.out_valid);
        end
        checks++;
        if (if0.busy !== 1'b0 || if7.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b/%b expected 0", if0.busy, if7.busy);
        end
        checks++;
        if (if0.feature_addr !== 8'hFF) begin
            errors++; $display("FAIL reset_addr: got %0h expected ff", if0.feature_addr);
        end
    endtask

    task automatic test_layer_c_ones();
        int lat, p0; logic [7:0] d0, d7; logic b3, b4;
        fill_mem(8'sd1, 8'sd1);
        addr_bad = 1'b0;
        p0 = pulses0;
        start_run(2'b10, 16'sd0);
        checks++;
        if (if0.busy !== 1'b1) begin
            errors++; $display("FAIL ones_busy_run: got %b expected 1", if0.busy);
        end
        feed(0, 19);
        wait_result(lat, d0, d7, b3, b4);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL ones_latency: got %0d expected 4", lat);
        end
        checks++;
        if (d0 !== 8'd20) begin
            errors++; $display("FAIL ones_data_shift0: got %0d expected 20", d0);
        end
        checks++;
        if (d7 !== 8'd0) begin
            errors++; $display("FAIL ones_data_shift7: got %0d expected 0", d7);
        end
        checks++;
        if (b3 !== 1'b1 || b4 !== 1'b0) begin
            errors++; $display("FAIL ones_busy_edge: got %b%b expected 10", b3, b4);
        end
        checks++;
        if (pulses0 - p0 !== 1) begin
            errors++; $display("FAIL ones_pulse_count: got %0d expected 1", pulses0 - p0);
        end
        checks++;
        if (addr_bad !== 1'b0) begin
            errors++; $display("FAIL ones_addr_follow: got %b expected 0", addr_bad);
        end
    endtask

    task automatic test_saturate();
        int lat, p0, p7; logic [7:0] d0, d7; logic b3, b4;
        fill_mem(8'sd127, 8'sd127);
        p0 = pulses0; p7 = pulses7;
        start_run(2'b00, 16'sd0);
        feed(0, 61);
        wait_result(lat, d0, d7, b3, b4);
        checks++;
        if (d7 !== 8'd255) begin
            errors++; $display("FAIL sat_shift7: got %0d expected 255", d7);
        end
        checks++;
        if (d0 !== 8'd255) begin
            errors++; $display("FAIL sat_shift0: got %0d expected 255", d0);
        end
        checks++;
        if (pulses0 - p0 !== 1 || pulses7 - p7 !== 1) begin
            errors++; $display("FAIL sat_pulse_count: got %0d/%0d expected 1/1", pulses0 - p0, pulses7 - p7);
        end
    endtask

    task automatic test_illegal_layer();
        int p0; logic busy_seen;
        fill_mem(8'sd3, 8'sd3);
        p0 = pulses0;
        busy_seen = 1'b0;
        start = 1'b1; ctrl = 2'b11; bias = 16'sd0; ready = 1'b1; index = 8'hFF;
        step();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            ready = 1'b0;
            index = 8'(i);
            if (if0.busy !== 1'b0 || if7.busy !== 1'b0) busy_seen = 1'b1;
            step();
        end
        ready = 1'b1; index = 8'hFF;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL illegal_busy: got %b expected 0", busy_seen);
        end
        checks++;
        if (pulses0 - p0 !== 0) begin
            errors++; $display("FAIL illegal_pulse: got %0d expected 0", pulses0 - p0);
        end
        checks++;
        if (if0.out_data !== 8'd255 || if7.out_data !== 8'd255) begin
            errors++; $display("FAIL illegal_hold: got %0d/%0d expected 255/255", if0.out_data, if7.out_data);
        end
    endtask

    task automatic test_negative();
        int lat, p0; logic [7:0] d0, d7; logic b3, b4;
        fill_mem(8'sd1, -8'sd1);
        p0 = pulses0;
        start_run(2'b10, 16'sd5);
        feed(0, 19);
        wait_result(lat, d0, d7, b3, b4);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL neg_latency: got %0d expected 4", lat);
        end
        checks++;
        if (d0 !== 8'd0 || d7 !== 8'd0) begin
            errors++; $display("FAIL neg_relu: got %0d/%0d expected 0/0", d0, d7);
        end
        checks++;
        if (pulses0 - p0 !== 1) begin
            errors++; $display("FAIL neg_pulse_count: got %0d expected 1", pulses0 - p0);
        end
    endtask

    task automatic test_restart();
        int lat, p0; logic [7:0] d0, d7; logic b3, b4;
        fill_mem(8'sd2, 8'sd2);
        p0 = pulses0;
        start_run(2'b00, 16'sd0);
        feed(0, 30);
        start_run(2'b10, 16'sd0);
        feed(0, 19);
        wait_result(lat, d0, d7, b3, b4);
        checks++;
        if (d0 !== 8'd80) begin
            errors++; $display("FAIL restart_data: got %0d expected 80", d0);
        end
        checks++;
        if (d7 !== 8'd0) begin
            errors++; $display("FAIL restart_data_shift7: got %0d expected 0", d7);
        end
        checks++;
        if (pulses0 - p0 !== 1) begin
            errors++; $display("FAIL restart_pulse_count: got %0d expected 1", pulses0 - p0);
        end
    endtask

    task automatic test_mid_reset();
        int lat; logic [7:0] d0, d7; logic b3, b4;
        fill_mem(8'sd1, 8'sd1);
        start_run(2'b00, 16'sd0);
        feed(0, 9);
        checks++;
        if (if0.busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b expected 1", if0.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if0.busy !== 1'b0 || if7.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_busy: got %b/%b expected 0", if0.busy, if7.busy);
        end
        checks++;
        if (if0.out_data !== 8'd0) begin
            errors++; $display("FAIL midrst_out_data: got %0d expected 0", if0.out_data);
        end
        checks++;
        if (if0.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_out_valid: got %b expected 0", if0.out_valid);
        end
        step();
        rst = 1'b0;
        step();
        start_run(2'b10, 16'sd0);
        feed(0, 19);
        wait_result(lat, d0, d7, b3, b4);
        checks++;
        if (d0 !== 8'd20 || lat !== 4) begin
            errors++; $display("FAIL midrst_fresh_run: got %0d at %0d expected 20 at 4", d0, lat);
        end
        checks++;
        if (d7 !== 8'd0) begin
            errors++; $display("FAIL midrst_fresh_shift7: got %0d expected 0", d7);
        end
    endtask

    initial begin
        checks = 0; errors = 0; pulses0 = 0; pulses7 = 0; addr_bad = 1'b0;
        rst = 1'b1; start = 1'b0; ctrl = 2'b00; ready = 1'b1; index = 8'hFF; bias = 16'sd0;
        fill_mem(8'sd0, 8'sd0);
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_layer_c_ones();
        test_saturate();
        test_illegal_layer();
        test_negative();
        test_restart();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
